// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM arbiter between instruction fetch and load/store ports
// Ports:
//   clk, rst (async active-low), rdy (global freeze), rob_clear (fetch flush)
//   if_req/if_addr -> if_ready/if_data        : 4-byte instruction fetch
//   ls_req/ls_wr/ls_size/ls_addr/ls_wdata -> ls_ready/ls_rdata : byte/half/word load-store
//   mem_din (1-cycle latency read byte), mem_dout/mem_a/mem_wr : RAM side
//   io_buffer_full : stalls stores into the UART window (ls_addr[17:16] == 2'b11)
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_cnt, w_n, w_ai;
  logic        r_last, r_if_ready, r_ls_ready;
  logic [31:0] r_buf, r_if_data, r_ls_rdata, w_word;
  logic        w_idle, w_if, w_gnt_if, w_gnt_ls, w_stall, w_done, w_flush;
  logic [1:0]  w_bi;
  assign if_ready = r_if_ready;
  assign ls_ready = r_ls_ready;
  assign if_data  = r_if_data;
  assign ls_rdata = r_ls_rdata;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_last     <= 1'b1;
      r_buf      <= 32'd0;
      r_if_ready <= 1'b0;
      r_ls_ready <= 1'b0;
      r_if_data  <= 32'd0;
      r_ls_rdata <= 32'd0;
    end else if (rdy) begin
      r_state    <= w_next;
      r_cnt      <= (r_state == IDLE || w_next == IDLE) ? 3'd0 : w_stall ? r_cnt : r_cnt + 3'd1;
      r_buf      <= r_state == IDLE ? 32'd0 : (r_state != STORE && r_cnt != 3'd0) ? w_word : r_buf;
      r_if_ready <= r_state == IFETCH && w_done && !rob_clear;
      r_ls_ready <= (r_state == LOAD || r_state == STORE) && w_done;
      r_last     <= w_gnt_if ? 1'b0 : w_gnt_ls ? 1'b1 : r_last;
      if (r_state == IFETCH && w_done && !rob_clear) r_if_data <= w_word;
      if (r_state == LOAD && w_done) r_ls_rdata <= w_word;
    end
  end
  always_comb begin
    w_n      = (r_state == IFETCH || ls_size[1]) ? 3'd4 : ls_size[0] ? 3'd2 : 3'd1;
    // a ready pulse still showing means the requester has not yet dropped its request
    w_idle   = r_state == IDLE && !r_if_ready && !r_ls_ready;
    w_if     = if_req && !rob_clear;
    w_gnt_if = w_idle && w_if && (!ls_req || r_last);
    w_gnt_ls = w_idle && ls_req && (!w_if || !r_last);
    w_stall  = r_state == STORE && io_buffer_full && ls_addr[17:16] == 2'b11;
    // reads need one extra cycle to collect the last byte from the RAM
    w_done   = r_state == STORE ? (!w_stall && r_cnt == w_n - 3'd1) : (r_state != IDLE && r_cnt == w_n);
    w_flush  = r_state == IFETCH && rob_clear;
    w_next   = r_state == IDLE ? (w_gnt_if ? IFETCH : w_gnt_ls ? (ls_wr ? STORE : LOAD) : IDLE)
                               : (w_done || w_flush) ? IDLE : r_state;
    w_bi     = r_cnt[1:0] - 2'd1;
    w_word   = r_buf;
    w_word[{w_bi, 3'b000} +: 8] = mem_din;
  end
  always_comb begin
    // while frozen, keep re-presenting the address whose byte is still owed so it is valid on resume
    w_ai     = (!rdy && r_cnt != 3'd0 && r_state != STORE) ? r_cnt - 3'd1 : r_cnt;
    mem_a    = r_state == IDLE ? 32'd0 : (r_state == IFETCH ? if_addr : ls_addr) + {29'd0, w_ai};
    mem_wr   = r_state == STORE && rdy && !w_stall;
    mem_dout = r_state == STORE ? ls_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector bench for mem_arbiter with a one-cycle-latency byte RAM model
module tb_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, rob_clear = 1'b0;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_wr = 1'b0, io_buffer_full = 1'b0;
  logic [31:0] if_addr = 32'd0, ls_addr = 32'd0, ls_wdata = 32'd0;
  logic [1:0]  ls_size = 2'd0;
  logic [7:0]  mem_din;
  logic        if_ready, ls_ready, mem_wr;
  logic [31:0] if_data, ls_rdata, mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  ram [logic [31:0]];
  logic [39:0] wr_log [$];
  int checks = 0, failures = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : (a[7:0] ^ 8'h5A);
  endfunction

  always @(posedge clk) begin
    mem_din <= rd(mem_a);
    if (mem_wr) begin
      ram[mem_a] = mem_dout;
      wr_log.push_back({mem_a, mem_dout});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input bit is_if, input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] data);
    lat = 0;
    data = 32'd0;
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata;
    end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (is_if ? if_ready : ls_ready) begin
        lat = k;
        data = is_if ? if_data : ls_rdata;
        break;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          is_if;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, n0, c_if1, c_if2, c_ls, k_ls;
    logic [31:0] d_if1, d_if2, d_ls, data;
    bit seen;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
    ram[32'h10]  = 8'h7F;
    ram[32'h50]  = 8'h81; ram[32'h51]  = 8'h82; ram[32'h52]  = 8'h83; ram[32'h53]  = 8'h84;
    ram[32'h60]  = 8'hEF; ram[32'h61]  = 8'hBE; ram[32'h62]  = 8'hAD; ram[32'h63]  = 8'hDE;
    vecs[0] = '{1'b0, 1'b0, 2'b01, 32'h52,  32'h0,        32'h00008483, 4};
    vecs[1] = '{1'b0, 1'b0, 2'b00, 32'h51,  32'h0,        32'h00000082, 3};
    vecs[2] = '{1'b0, 1'b0, 2'b11, 32'h60,  32'h0,        32'hDEADBEEF, 6};
    vecs[3] = '{1'b0, 1'b1, 2'b10, 32'h70,  32'h01020304, 32'hDEADBEEF, 5};
    vecs[4] = '{1'b0, 1'b0, 2'b10, 32'h70,  32'h0,        32'h01020304, 6};
    vecs[5] = '{1'b0, 1'b1, 2'b00, 32'h80,  32'hFFFFFF99, 32'h01020304, 2};
    vecs[6] = '{1'b0, 1'b0, 2'b10, 32'h80,  32'h0,        32'hD9D8DB99, 6};
    vecs[7] = '{1'b1, 1'b0, 2'b00, 32'h100, 32'h0,        32'h00000013, 6};
    vecs[8] = '{1'b0, 1'b0, 2'b10, 32'h200, 32'h0,        32'h44332211, 6};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_ls_ready", {31'd0, ls_ready}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);

    // contention straight out of reset: fetch first, then load, then the re-issued fetch
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
    c_if1 = 0; c_if2 = 0; c_ls = 0; d_if1 = 0; d_if2 = 0; d_ls = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c <= 4) chk($sformatf("fetch_mem_a_T+%0d", c), mem_a, 32'h100 + c - 1);
      if (if_ready) begin
        if (c_if1 == 0) begin
          c_if1 = c; d_if1 = if_data;
          chk("ready_cycle_mem_a_idle", mem_a, 32'd0);
          if_addr = 32'h104;
        end else begin
          c_if2 = c; d_if2 = if_data; if_req = 1'b0;
        end
      end
      if (ls_ready) begin
        c_ls = c; d_ls = ls_rdata; ls_req = 1'b0;
      end
    end
    chk("cont_fetch1_cycle", c_if1, 6);
    chk("cont_fetch1_data", d_if1, 32'h00000013);
    chk("cont_load_cycle", c_ls, 13);
    chk("cont_load_data", d_ls, 32'h44332211);
    chk("cont_fetch2_cycle", c_if2, 20);
    chk("cont_fetch2_data", d_if2, 32'h5D5C5F5E);

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].is_if, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat, data);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end

    // half store: exactly two bytes written
    wr_log.delete();
    do_req(1'b0, 1'b1, 2'b01, 32'h40, 32'hAABBCCDD, lat, data);
    chk("half_store_latency", lat, 3);
    chk("half_store_writes", wr_log.size(), 2);
    chk("half_store_w0", {wr_log[0][39:8], 8'h00} | {24'd0, wr_log[0][7:0]}, 32'h000040DD);
    chk("half_store_w1", {wr_log[1][39:8], 8'h00} | {24'd0, wr_log[1][7:0]}, 32'h000041CC);

    // store into the UART window held off by io_buffer_full
    n0 = wr_log.size();
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b00; ls_addr = 32'h30000; ls_wdata = 32'h55;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("io_stall_wr_%0d", c), {31'd0, mem_wr}, 32'd0);
    end
    io_buffer_full = 1'b0;
    #1;
    chk("io_release_wr", {31'd0, mem_wr}, 32'd1);
    chk("io_release_addr", mem_a, 32'h30000);
    chk("io_release_dout", {24'd0, mem_dout}, 32'h55);
    @(posedge clk); #1;
    chk("io_store_ready", {31'd0, ls_ready}, 32'd1);
    ls_req = 1'b0;
    chk("io_store_writes", wr_log.size() - n0, 1);
    @(posedge clk); #1;

    // flush in fetch busy cycle 2 with a pending byte load
    if_req = 1'b1; if_addr = 32'h100;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h50;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rob_clear = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    rob_clear = 1'b0;
    chk("flush_idle_mem_a", mem_a, 32'd0);
    seen = if_ready;
    k_ls = 0; d_ls = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("flush_ls_granted_addr", mem_a, 32'h50);
      seen |= if_ready;
      if (ls_ready && k_ls == 0) begin
        k_ls = k; d_ls = ls_rdata; ls_req = 1'b0;
      end
    end
    chk("flush_no_if_ready", {31'd0, seen}, 32'd0);
    chk("flush_ls_ready_cycle", k_ls, 3);
    chk("flush_ls_data", d_ls, 32'h00000081);

    // freeze during the capture cycle of a byte load
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h10;
    @(posedge clk); #1;
    chk("freeze_busy0_addr", mem_a, 32'h10);
    @(posedge clk); #1;
    rdy = 1'b0;
    #1;
    chk("freeze_readdr", mem_a, 32'h10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("freeze_no_ready", {31'd0, ls_ready}, 32'd0);
    @(posedge clk); #1;
    rdy = 1'b1;
    k_ls = 0; d_ls = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (ls_ready && k_ls == 0) begin
        k_ls = k; d_ls = ls_rdata; ls_req = 1'b0;
      end
    end
    chk("freeze_ready_cycle", k_ls, 1);
    chk("freeze_data", d_ls, 32'h0000007F);

    // reset in the middle of a word store
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h90; ls_wdata = 32'h11223344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midstore_wr_before_rst", {31'd0, mem_wr}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("midrst_mem_a", mem_a, 32'd0);
    chk("midrst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("midrst_if_data", if_data, 32'd0);
    chk("midrst_ls_rdata", ls_rdata, 32'd0);
    chk("midrst_readies", {30'd0, if_ready, ls_ready}, 32'd0);
    n0 = wr_log.size();
    ls_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      seen |= ls_ready;
    end
    chk("midrst_no_ls_ready", {31'd0, seen}, 32'd0);
    chk("midrst_no_more_writes", wr_log.size() - n0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
